// File: rtl/dl11_pkg.sv
// Shared definitions for the DL11 console transmitter: register offsets,
// CSR bit positions, default vector and serializer states.
package dl11_pkg;

  localparam logic [15:0] XCSR_OFS       = 16'd0;
  localparam logic [15:0] XBUF_OFS       = 16'd2;
  localparam int unsigned CSR_READY      = 7;
  localparam int unsigned CSR_IE         = 6;
  localparam logic [15:0] DEFAULT_VECTOR = 16'o64;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_START,
    SER_DATA,
    SER_STOP
  } ser_state_t;

endpackage

// File: rtl/dl11_tx_port_uart_tx_ser.sv
// 8N1 serializer: start bit, eight data bits LSB first, stop bit; each bit
// lasts CLK_DIV ce-cycles. done pulses for one ce-cycle after the stop bit.
module uart_tx_ser
  import dl11_pkg::*;
#(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       load,
  input  logic [7:0] data,
  input  logic       abort,
  output logic       txd,
  output logic       done
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  ser_state_t    state;
  logic [DW-1:0] div;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          bit_end;

  assign bit_end = (div == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= SER_IDLE;
      div    <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      txd    <= 1'b1;
      done   <= 1'b0;
    end else if (ce) begin
      done <= 1'b0;
      if (abort) begin
        state <= SER_IDLE;
        div   <= '0;
        txd   <= 1'b1;
      end else begin
        case (state)
          SER_IDLE: begin
            if (load) begin
              state <= SER_START;
              shreg <= data;
              div   <= '0;
              txd   <= 1'b0;
            end
          end
          default: begin
            div <= bit_end ? '0 : div + 1'b1;
            if (bit_end) begin
              case (state)
                SER_START: begin
                  state  <= SER_DATA;
                  bitcnt <= '0;
                  txd    <= shreg[0];
                  shreg  <= {1'b0, shreg[7:1]};
                end
                SER_DATA: begin
                  if (bitcnt == 3'd7) begin
                    state <= SER_STOP;
                    txd   <= 1'b1;
                  end else begin
                    bitcnt <= bitcnt + 1'b1;
                    txd    <= shreg[0];
                    shreg  <= {1'b0, shreg[7:1]};
                  end
                end
                SER_STOP: begin
                  state <= SER_IDLE;
                  done  <= 1'b1;
                end
                default: state <= SER_IDLE;
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/dl11_tx_port.sv
// DL11 console transmitter on the vm1 bus: XCSR/XBUF decode, RPLY handshake,
// vectored interrupt with IAKO acknowledge, and the 8N1 line serializer.
module dl11_tx_port
  import dl11_pkg::*;
#(
  parameter logic [15:0]  BASE_ADDR = 16'o177564,
  parameter logic [15:0]  VECTOR    = DEFAULT_VECTOR,
  parameter int unsigned  CLK_DIV   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] addr_i,
  input  logic [15:0] data_i,
  output logic [15:0] data_o,
  output logic        sel_o,
  input  logic        sync_i,
  input  logic        din_i,
  input  logic        dout_i,
  input  logic        wtbt_i,
  output logic        rply_o,
  input  logic        init_i,
  output logic        virq_o,
  input  logic        iako_i,
  output logic        txd_o
);

  localparam logic [15:0] XCSR_ADDR = BASE_ADDR + XCSR_OFS;
  localparam logic [15:0] XBUF_ADDR = BASE_ADDR + XBUF_OFS;

  logic ready, ie, irq, rply, ack_q;
  logic ready_n, ie_n, irq_n;
  logic hit_csr, hit_buf, bus_cyc, ack_cyc, start, wr_ok;
  logic csr_wr, buf_wr, ack_fire;
  logic ser_done, ser_txd;
  logic unused_bits;

  assign hit_csr  = sync_i & (addr_i[15:1] == XCSR_ADDR[15:1]);
  assign hit_buf  = sync_i & (addr_i[15:1] == XBUF_ADDR[15:1]);
  assign bus_cyc  = (hit_csr | hit_buf) & ~iako_i & (din_i | dout_i);
  // ack_q keeps the vector cycle alive after the request latch has cleared
  assign ack_cyc  = iako_i & din_i & (irq | ack_q);
  assign start    = ~rply & bus_cyc;
  assign wr_ok    = ~wtbt_i | ~addr_i[0];
  assign csr_wr   = start & dout_i & hit_csr & wr_ok & ~init_i;
  assign buf_wr   = start & dout_i & hit_buf & wr_ok & ready & ~init_i;
  assign ack_fire = ~rply & iako_i & din_i & irq;

  assign unused_bits = &{1'b0, data_i[15:8]};

  // Request sets on the rising edge of (IE & READY), so a simultaneous IE set
  // and READY rise produce a single request.
  always_comb begin
    ready_n = ready;
    ie_n    = ie;
    irq_n   = irq;
    if (ser_done) ready_n = 1'b1;
    if (buf_wr)   ready_n = 1'b0;
    if (csr_wr)   ie_n    = data_i[CSR_IE];
    if (init_i) begin
      ready_n = 1'b1;
      ie_n    = 1'b0;
    end
    if (init_i || !ie_n)
      irq_n = 1'b0;
    else if (ready_n && !(ready && ie))
      irq_n = 1'b1;
    else if (ack_fire)
      irq_n = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready <= 1'b1;
      ie    <= 1'b0;
      irq   <= 1'b0;
      rply  <= 1'b0;
      ack_q <= 1'b0;
    end else if (ce) begin
      ready <= ready_n;
      ie    <= ie_n;
      irq   <= irq_n;
      rply  <= bus_cyc | ack_cyc;
      ack_q <= ack_cyc;
    end
  end

  always_comb begin
    data_o = '0;
    sel_o  = 1'b0;
    if (ack_cyc) begin
      sel_o  = 1'b1;
      data_o = VECTOR;
    end else if (din_i & ~iako_i & (hit_csr | hit_buf)) begin
      sel_o = 1'b1;
      if (hit_csr) begin
        data_o[CSR_READY] = ready;
        data_o[CSR_IE]    = ie;
      end
    end
  end

  uart_tx_ser #(
    .CLK_DIV(CLK_DIV)
  ) u_ser (
    .clk  (clk),
    .reset(reset),
    .ce   (ce),
    .load (buf_wr),
    .data (data_i[7:0]),
    .abort(init_i),
    .txd  (ser_txd),
    .done (ser_done)
  );

  assign rply_o = rply;
  assign virq_o = irq;
  assign txd_o  = ser_txd;

endmodule

// File: tb/tb_dl11_tx_port.sv
// Self-checking bench for dl11_tx_port: bus handshake, CSR, interrupt/IAKO,
// INIT abort and the serial line checked against a frame-timing model.
module tb_dl11_tx_port;

  localparam int unsigned CLK_DIV = 16;
  localparam logic [15:0] BASE    = 16'o177564;
  localparam logic [15:0] XBUF_A  = 16'o177566;
  localparam int          FRAME   = 10 * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset, ce;
  logic [15:0] addr, wdata, data_o;
  logic        sel_o, sync, din, dout, wtbt, rply_o, init, virq_o, iako, txd_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  bit         mon_en   = 1'b0;
  bit         m_active = 1'b0;
  int         m_acc    = 0;
  logic [9:0] m_frame  = '1;

  dl11_tx_port #(
    .BASE_ADDR(BASE),
    .VECTOR   (16'o64),
    .CLK_DIV  (CLK_DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .addr_i(addr),
    .data_i(wdata),
    .data_o(data_o),
    .sel_o (sel_o),
    .sync_i(sync),
    .din_i (din),
    .dout_i(dout),
    .wtbt_i(wtbt),
    .rply_o(rply_o),
    .init_i(init),
    .virq_o(virq_o),
    .iako_i(iako),
    .txd_o (txd_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (ce) cyc <= cyc + 1;

  // Line level k ce-cycles after acceptance: frame bit k/CLK_DIV, idle after.
  function automatic logic model_txd();
    int k = cyc - m_acc;
    if (m_active && k < FRAME) return m_frame[k / CLK_DIV];
    return 1'b1;
  endfunction

  function automatic bit model_ready();
    return !m_active || (cyc - m_acc) > FRAME;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (txd_o !== model_txd()) begin
        errors++;
        $display("FAIL txd k=%0d got=%b exp=%b", cyc - m_acc, txd_o, model_txd());
      end
    end
  end

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d, output logic s,
                          output logic r0, output logic r1, output logic r2);
    @(negedge clk);
    addr = a; sync = 1'b1; din = 1'b1; wtbt = 1'b0;
    #1 d = data_o; s = sel_o; r0 = rply_o;
    @(negedge clk);
    r1 = rply_o;
    din = 1'b0; sync = 1'b0;
    @(negedge clk);
    r2 = rply_o;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input logic bw,
                           output logic r0, output logic r1, output logic v1, output logic r2);
    bit acc;
    @(negedge clk);
    addr = a; wdata = d; wtbt = bw; sync = 1'b1; dout = 1'b1;
    acc = model_ready() && (a[15:1] == XBUF_A[15:1]) && (!bw || !a[0]);
    #1 r0 = rply_o;
    @(posedge clk);
    #1;
    if (acc) begin
      m_active = 1'b1;
      m_acc    = cyc;
      m_frame  = {1'b1, d[7:0], 1'b0};
    end
    @(negedge clk);
    r1 = rply_o; v1 = virq_o;
    dout = 1'b0; sync = 1'b0; wtbt = 1'b0;
    @(negedge clk);
    r2 = rply_o;
  endtask

  // Combinational look at XCSR at the current instant; no bus cycle completes.
  task automatic peek(output logic [15:0] d);
    addr = BASE; sync = 1'b1; din = 1'b1;
    #1 d = data_o;
    sync = 1'b0; din = 1'b0;
  endtask

  task automatic wait_k(input int n);
    int guard = 0;
    while ((cyc - m_acc) < n && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if ((cyc - m_acc) != n) begin
      errors++;
      $display("FAIL wait_k got=%0d exp=%0d", cyc - m_acc, n);
    end
  endtask

  task automatic iack(output logic s, output logic [15:0] d, output logic r0,
                      output logic r1, output logic v1, output logic r2);
    @(negedge clk);
    iako = 1'b1; din = 1'b1;
    #1 s = sel_o; d = data_o; r0 = rply_o;
    @(negedge clk);
    r1 = rply_o; v1 = virq_o;
    iako = 1'b0; din = 1'b0;
    @(negedge clk);
    r2 = rply_o;
  endtask

  task automatic test_reset();
    logic [15:0] d; logic s, r0, r1, r2;
    reset = 1'b1; ce = 1'b1; addr = '0; wdata = '0; sync = 1'b0; din = 1'b0;
    dout = 1'b0; wtbt = 1'b0; init = 1'b0; iako = 1'b0;
    #1;
    checks++;
    if ({txd_o, virq_o, rply_o, sel_o, data_o} !== {4'b1000, 16'h0}) begin
      errors++;
      $display("FAIL reset_outputs got=%b_%b_%b_%b_%o exp=1_0_0_0_0", txd_o, virq_o, rply_o, sel_o, data_o);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    bus_read(BASE, d, s, r0, r1, r2);
    checks++;
    if ({d, s, r0, r1, r2} !== {16'o200, 4'b1010}) begin
      errors++;
      $display("FAIL reset_read got=%o sel=%b rply=%b%b%b exp=200 sel=1 rply=010", d, s, r0, r1, r2);
    end
    checks++;
    if ({txd_o, virq_o} !== 2'b10) begin
      errors++;
      $display("FAIL reset_line got txd=%b virq=%b exp txd=1 virq=0", txd_o, virq_o);
    end
  endtask

  task automatic test_tx_frame(input logic [7:0] b, input logic bw);
    logic [15:0] d; logic r0, r1, v1, r2;
    bus_write(XBUF_A, {8'($urandom), b}, bw, r0, r1, v1, r2);
    checks++;
    if ({r0, r1, r2} !== 3'b010) begin
      errors++;
      $display("FAIL tx_rply got=%b%b%b exp=010", r0, r1, r2);
    end
    wait_k(80);
    peek(d);
    checks++;
    if (d !== 16'o0) begin errors++; $display("FAIL tx_busy_csr got=%o exp=0", d); end
    wait_k(FRAME);
    peek(d);
    checks++;
    if (d !== 16'o0) begin errors++; $display("FAIL tx_ready_early got=%o exp=0", d); end
    wait_k(FRAME + 1);
    peek(d);
    checks++;
    if (d !== 16'o200) begin errors++; $display("FAIL tx_ready_back got=%o exp=200", d); end
  endtask

  task automatic test_busy_write(input logic [7:0] first, input logic [7:0] second);
    logic [15:0] d; logic r0, r1, v1, r2;
    bus_write(XBUF_A, {8'h0, first}, 1'b0, r0, r1, v1, r2);
    wait_k(40);
    bus_write(XBUF_A, {8'h0, second}, 1'b0, r0, r1, v1, r2);
    checks++;
    if ({r0, r1, r2} !== 3'b010) begin
      errors++;
      $display("FAIL busy_rply got=%b%b%b exp=010", r0, r1, r2);
    end
    wait_k(FRAME);
    peek(d);
    checks++;
    if (d !== 16'o0) begin errors++; $display("FAIL busy_ready_early got=%o exp=0", d); end
    wait_k(FRAME + 1);
    peek(d);
    checks++;
    if (d !== 16'o200) begin errors++; $display("FAIL busy_ready_back got=%o exp=200", d); end
  endtask

  task automatic test_interrupt();
    logic [15:0] d; logic s, r0, r1, v1, r2;
    bus_write(BASE, 16'o100, 1'b0, r0, r1, v1, r2);
    checks++;
    if ({r1, v1} !== 2'b11) begin
      errors++;
      $display("FAIL ie_set_virq got rply=%b virq=%b exp 1 1", r1, v1);
    end
    iack(s, d, r0, r1, v1, r2);
    checks++;
    if ({s, d, r0, r1, v1, r2} !== {1'b1, 16'o64, 4'b0100}) begin
      errors++;
      $display("FAIL iack got sel=%b d=%o rply=%b%b virq=%b rply_end=%b exp sel=1 d=64 rply=01 virq=0 rply_end=0",
               s, d, r0, r1, v1, r2);
    end
    iack(s, d, r0, r1, v1, r2);
    checks++;
    if ({s, d, r1} !== 18'b0) begin
      errors++;
      $display("FAIL iack_idle got sel=%b d=%o rply=%b exp 0 0 0", s, d, r1);
    end
    bus_write(XBUF_A, 16'($urandom_range(0, 255)), 1'b0, r0, r1, v1, r2);
    wait_k(FRAME);
    checks++;
    if (virq_o !== 1'b0) begin errors++; $display("FAIL virq_early got=%b exp=0", virq_o); end
    wait_k(FRAME + 1);
    checks++;
    if (virq_o !== 1'b1) begin errors++; $display("FAIL virq_reassert got=%b exp=1", virq_o); end
    bus_write(BASE, 16'o0, 1'b0, r0, r1, v1, r2);
    checks++;
    if (v1 !== 1'b0) begin errors++; $display("FAIL ie_clear_virq got=%b exp=0", v1); end
    // IE set lands on the same edge READY rises
    bus_write(XBUF_A, 16'($urandom_range(0, 255)), 1'b0, r0, r1, v1, r2);
    wait_k(FRAME - 1);
    bus_write(BASE, 16'o100, 1'b0, r0, r1, v1, r2);
    checks++;
    if (v1 !== 1'b1) begin errors++; $display("FAIL simult_virq got=%b exp=1", v1); end
    iack(s, d, r0, r1, v1, r2);
    repeat (3) @(negedge clk);
    checks++;
    if ({r1, virq_o} !== 2'b10) begin
      errors++;
      $display("FAIL simult_once got rply=%b virq=%b exp 1 0", r1, virq_o);
    end
    bus_write(BASE, 16'o0, 1'b0, r0, r1, v1, r2);
  endtask

  task automatic test_init();
    logic [15:0] d; logic r0, r1, v1, r2;
    bus_write(BASE, 16'o100, 1'b0, r0, r1, v1, r2);
    bus_write(XBUF_A, 16'($urandom_range(0, 255)), 1'b0, r0, r1, v1, r2);
    wait_k(5 * CLK_DIV + int'($urandom_range(0, CLK_DIV - 1)));
    init = 1'b1;
    @(posedge clk);
    #1 m_active = 1'b0;
    @(negedge clk);
    init = 1'b0;
    checks++;
    if ({txd_o, virq_o} !== 2'b10) begin
      errors++;
      $display("FAIL init_line got txd=%b virq=%b exp txd=1 virq=0", txd_o, virq_o);
    end
    peek(d);
    checks++;
    if (d !== 16'o200) begin errors++; $display("FAIL init_csr got=%o exp=200", d); end
    // INIT concurrent with an XBUF write: write must be dropped
    @(negedge clk);
    init = 1'b1; addr = XBUF_A; wdata = 16'o125; wtbt = 1'b0; sync = 1'b1; dout = 1'b1;
    @(negedge clk);
    init = 1'b0;
    checks++;
    if (rply_o !== 1'b1) begin errors++; $display("FAIL init_wr_rply got=%b exp=1", rply_o); end
    sync = 1'b0; dout = 1'b0;
    repeat (4) @(negedge clk);
    peek(d);
    checks++;
    if (d !== 16'o200) begin errors++; $display("FAIL init_wins got=%o exp=200", d); end
  endtask

  task automatic test_byte_and_miss();
    logic [15:0] d; logic s, r0, r1, v1, r2;
    bus_write(BASE + 16'd1, 16'o100, 1'b1, r0, r1, v1, r2);
    peek(d);
    checks++;
    if ({d, virq_o, r1} !== {16'o200, 2'b01}) begin
      errors++;
      $display("FAIL odd_byte got csr=%o virq=%b rply=%b exp csr=200 virq=0 rply=1", d, virq_o, r1);
    end
    bus_write(BASE, 16'o100, 1'b1, r0, r1, v1, r2);
    peek(d);
    checks++;
    if ({d, virq_o} !== {16'o300, 1'b1}) begin
      errors++;
      $display("FAIL even_byte got csr=%o virq=%b exp csr=300 virq=1", d, virq_o);
    end
    bus_write(BASE, 16'o0, 1'b0, r0, r1, v1, r2);
    bus_read(XBUF_A, d, s, r0, r1, r2);
    checks++;
    if ({d, s, r1} !== {16'o0, 2'b11}) begin
      errors++;
      $display("FAIL xbuf_read got d=%o sel=%b rply=%b exp 0 1 1", d, s, r1);
    end
    bus_read(16'o177000, d, s, r0, r1, r2);
    checks++;
    if ({d, s, r0, r1, r2} !== 20'b0) begin
      errors++;
      $display("FAIL miss_177000 got d=%o sel=%b rply=%b%b%b exp all 0", d, s, r0, r1, r2);
    end
    for (int i = 0; i < 4; i++) begin
      logic [15:0] a;
      a = 16'($urandom_range(0, 'o177000));
      bus_read(a, d, s, r0, r1, r2);
      checks++;
      if ({d, s, r1} !== 18'b0) begin
        errors++;
        $display("FAIL miss_rand a=%o got d=%o sel=%b rply=%b exp 0 0 0", a, d, s, r1);
      end
    end
  endtask

  task automatic test_ce_hold();
    logic [15:0] d; logic r0, r1, v1, r2; bit held;
    @(negedge clk);
    ce = 1'b0; addr = BASE; sync = 1'b1; din = 1'b1;
    held = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rply_o !== 1'b0) held = 1'b0;
    end
    checks++;
    if (!held) begin errors++; $display("FAIL ce_rply_hold got=1 exp=0"); end
    ce = 1'b1;
    @(negedge clk);
    checks++;
    if (rply_o !== 1'b1) begin errors++; $display("FAIL ce_rply_rise got=%b exp=1", rply_o); end
    sync = 1'b0; din = 1'b0;
    @(negedge clk);
    bus_write(XBUF_A, 16'($urandom_range(0, 255)), 1'b0, r0, r1, v1, r2);
    wait_k(int'($urandom_range(20, 120)));
    ce = 1'b0;
    repeat (int'($urandom_range(2, 6))) @(negedge clk);
    ce = 1'b1;
    wait_k(FRAME);
    peek(d);
    checks++;
    if (d !== 16'o0) begin errors++; $display("FAIL ce_ready_early got=%o exp=0", d); end
    wait_k(FRAME + 1);
    peek(d);
    checks++;
    if (d !== 16'o200) begin errors++; $display("FAIL ce_ready_back got=%o exp=200", d); end
  endtask

  initial begin
    test_reset();
    test_tx_frame(8'o101, 1'b0);
    for (int i = 0; i < 3; i++) test_tx_frame(8'($urandom), 1'($urandom));
    test_busy_write(8'o101, 8'o102);
    test_busy_write(8'($urandom), 8'($urandom));
    test_interrupt();
    test_init();
    test_byte_and_miss();
    test_ce_hold();
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dl11_tx_port.md
Name: dl11_tx_port

Overview:
- Synthesizable console transmitter slave on the vm1 handshake bus (SYNC/DIN/DOUT/WTBT/RPLY/VIRQ/IAKO).
- Replaces the behavioural TX CSR/XBUF model used in simulation.
- Implements the XCSR/XBUF register pair with a vectored interrupt and an 8N1 serializer on `txd_o`.
- Sits directly on the CPU bus, beside RAM decode.

Parameters:
- BASE_ADDR, 'o177564: XCSR address; XBUF is at BASE_ADDR+2.
- VECTOR, 'o64: interrupt vector returned during IAKO.
- CLK_DIV, 16: ce-qualified clocks per serial bit, ≥2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce  in  1  clock enable; all state advances only when ce=1
- addr_i  in  16  CPU address (addr_o of vm1)
- data_i  in  16  CPU write data
- data_o  out  16  read data / vector; 0 when not selected
- sel_o  out  1  this block is driving data_o (for the bus read mux)
- sync_i  in  1  address valid
- din_i  in  1  read strobe
- dout_i  in  1  write strobe
- wtbt_i  in  1  byte operation
- rply_o  out  1  reply to DIN/DOUT/IAKO read
- init_i  in  1  peripheral INIT from CPU
- virq_o  out  1  interrupt request
- iako_i  in  1  interrupt acknowledge
- txd_o  out  1  serial output, idle high

Behaviour:
- **Reset values** (reset=1, async): txd_o=1, READY=1, IE=0, rply_o=0, virq_o=0, data_o=0, sel_o=0, irq latch=0, serializer idle.
- **Address match:**
  - hit = sync_i & addr_i[15:1] equals BASE_ADDR[15:1] or (BASE_ADDR+2)[15:1].
  - Miss: rply_o, sel_o and data_o stay 0.
- **RPLY handshake:**
  - rply_o rises one ce-cycle after (hit & (din_i|dout_i)).
  - Held while the strobe is high; drops the cycle after the strobe falls or sync_i falls.
- **Write side effects:** occur exactly once per DOUT, on the cycle rply_o rises.
- **Reads:**
  - XCSR = {8'b0, READY, IE, 6'b0}.
  - XBUF reads 0.
  - data_o and sel_o are valid while din_i & hit.
- **XCSR write:**
  - Word write, or byte write to an even address: IE <= data_i[6].
  - READY is read-only.
  - Byte write to odd address BASE_ADDR+1 is ignored.
- **XBUF write:**
  - Word write, or byte write at even address, with READY=1: latch data_i[7:0], READY<=0, start serializer.
  - Write with READY=0: data discarded, RPLY still given.
- **Serializer:**
  - Sequence: start bit (0), data bits 0..7 LSB first, stop bit (1); each bit lasts CLK_DIV ce-cycles.
  - Start bit begins the ce-cycle after the write is accepted.
  - READY returns to 1 on the ce-cycle after the stop bit completes, i.e. 10*CLK_DIV+1 ce-cycles after acceptance.
  - Serializer states: IDLE, START, DATA(bit counter 0..7), STOP.
- **Interrupt:**
  - Request latch sets on a READY 0->1 edge while IE=1, or on an IE 0->1 edge while READY=1.
  - Latch clears on IE=0, on INIT, or on acknowledge.
  - virq_o = latch.
- **Acknowledge:**
  - iako_i & din_i & latch=1: data_o=VECTOR, sel_o=1, rply_o by the same timing rule.
  - Latch clears on the cycle rply_o rises.
  - IAKO with latch=0: no reply, sel_o=0.
- **INIT** (synchronous, ce-qualified): IE=0, READY=1, latch=0, serializer to IDLE, txd_o=1. INIT mid-character aborts the character immediately.
- **Simultaneous events:**
  - XCSR write setting IE in the same cycle READY rises: latch sets once.
  - INIT wins over any concurrent write.
- **ce=0:** all registers hold; rply_o holds.

Decomposition:
- Package dl11_pkg holds:
  - register offsets: XCSR=0, XBUF=2;
  - CSR bit positions: READY=7, IE=6;
  - default vector 'o64;
  - serializer state enum.
- One sub-module, uart_tx_ser:
  - inputs: clk, reset, ce, load, data[7:0], abort;
  - outputs: txd, done pulse;
  - parameter CLK_DIV;
  - contains the divider, bit counter and shift register.
- Bus decode, CSR and interrupt logic stay in dl11_tx_port.

Test Plan:
- **Reset, then read 'o177564 (word)** -> data_o='o200, rply_o one cycle after din_i, txd_o=1, virq_o=0.
- **Word write 'o101 to 'o177566, CLK_DIV=16** -> XCSR reads 0 during transmission; txd_o shows 0, then 1,0,0,0,0,0,1,0, then 1, each 16 cycles; XCSR reads 'o200 at 161 ce-cycles.
- **Write 'o100 to XCSR while READY=1** -> virq_o=1 next cycle; IAKO+DIN -> data_o='o64, rply_o=1, virq_o=0; re-asserts after the next character completes.
- **Second XBUF write 'o102 while busy** -> RPLY given; line still carries 'o101 only; READY timing unchanged.
- **init_i pulse at bit 4 of a character** -> txd_o=1 the next cycle, XCSR reads 'o200, IE=0, virq_o=0.
- **Byte write to 'o177565 with data 'o100; read of 'o177000** -> IE unchanged; 'o177000 read gives no rply_o and sel_o=0.
